// File: rtl/data_write_buffer.sv
// data_write_buffer
//   Posted-write buffer between the core's SRAM-like data port and the
//   SRAM-to-AXI bridge's data port. Stores are acknowledged one cycle after
//   acceptance and queued in a DEPTH-entry FIFO that drains one transaction
//   at a time. Loads reach the bridge only when ordering against the queued
//   stores is safe. Both request types complete in order toward the core.
//
//   Optional build macro: WBUF_READ_BYPASS_EN
//     defined   : a load may overtake queued stores unless one of them
//                 (including the in-flight head) targets the same 32-bit word
//     undefined : a load waits until the FIFO is completely drained
//
// Parameters
//   DEPTH : buffered store entries (power of two, >= 2)
//   AW    : address width
//
// Ports
//   clk, reset            : clock, synchronous active-high reset
//   up_req/up_wr/up_size/up_wstrb/up_addr/up_wdata : core request
//   up_addr_ok            : request accepted this cycle
//   up_data_ok/up_rdata   : completion (load data or store ack)
//   dn_req/dn_wr/dn_size/dn_wstrb/dn_addr/dn_wdata : bridge request
//   dn_addr_ok            : bridge accepted the request
//   dn_data_ok/dn_rdata   : bridge completion and load data
module data_write_buffer #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          up_req,
    input  logic          up_wr,
    input  logic [1:0]    up_size,
    input  logic [3:0]    up_wstrb,
    input  logic [AW-1:0] up_addr,
    input  logic [31:0]   up_wdata,
    output logic          up_addr_ok,
    output logic          up_data_ok,
    output logic [31:0]   up_rdata,
    output logic          dn_req,
    output logic          dn_wr,
    output logic [1:0]    dn_size,
    output logic [3:0]    dn_wstrb,
    output logic [AW-1:0] dn_addr,
    output logic [31:0]   dn_wdata,
    input  logic          dn_addr_ok,
    input  logic          dn_data_ok,
    input  logic [31:0]   dn_rdata
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_WAIT,
        RD_REQ,
        RD_WAIT
    } state_t;

    state_t        state;

    logic [AW-1:0] mem_addr  [DEPTH];
    logic [1:0]    mem_size  [DEPTH];
    logic [3:0]    mem_wstrb [DEPTH];
    logic [31:0]   mem_wdata [DEPTH];

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          ack_flag;

    logic [AW-1:0] rd_addr;
    logic [1:0]    rd_size;
    logic [31:0]   rdata_q;

    logic          full;
    logic          rd_busy;
    logic          rd_allowed;
    logic          st_accept;
    logic          ld_accept;
    logic          pop;

    assign full    = (count == CW'(DEPTH));
    assign rd_busy = (state == RD_REQ) || (state == RD_WAIT);
    assign pop     = (state == WR_WAIT) && dn_data_ok;

`ifdef WBUF_READ_BYPASS_EN
    // Scan every occupied slot, head included, for a store to the same word.
    always_comb begin
        rd_allowed = 1'b1;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if ((CW'(i) < count) &&
                (mem_addr[rd_ptr + PW'(i)][AW-1:2] == up_addr[AW-1:2])) begin
                rd_allowed = 1'b0;
            end
        end
    end
`else
    assign rd_allowed = (count == '0);
`endif

    // Nothing is accepted while reset is held; the request would be discarded.
    assign st_accept = !reset && up_req && up_wr && !full && !rd_busy;
    assign ld_accept = !reset && up_req && !up_wr && (state == IDLE) &&
                       rd_allowed && !ack_flag;

    assign up_addr_ok = st_accept || ld_accept;
    assign up_data_ok = ack_flag || ((state == RD_WAIT) && dn_data_ok);
    assign up_rdata   = (state == RD_WAIT) ? dn_rdata : rdata_q;

    // Bridge request fields come straight from the FIFO head or the read
    // register; both are stable until the request is taken.
    always_comb begin
        dn_req   = 1'b0;
        dn_wr    = 1'b0;
        dn_size  = '0;
        dn_wstrb = '0;
        dn_addr  = '0;
        dn_wdata = '0;
        case (state)
            WR_REQ: begin
                dn_req   = 1'b1;
                dn_wr    = 1'b1;
                dn_size  = mem_size[rd_ptr];
                dn_wstrb = mem_wstrb[rd_ptr];
                dn_addr  = mem_addr[rd_ptr];
                dn_wdata = mem_wdata[rd_ptr];
            end
            RD_REQ: begin
                dn_req  = 1'b1;
                dn_size = rd_size;
                dn_addr = rd_addr;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            ack_flag <= 1'b0;
            rd_addr  <= '0;
            rd_size  <= '0;
            rdata_q  <= '0;
        end else begin
            ack_flag <= st_accept;

            if (st_accept) begin
                mem_addr[wr_ptr]  <= up_addr;
                mem_size[wr_ptr]  <= up_size;
                mem_wstrb[wr_ptr] <= up_wstrb;
                mem_wdata[wr_ptr] <= up_wdata;
                wr_ptr            <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (st_accept && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !st_accept) begin
                count <= count - CW'(1);
            end

            case (state)
                IDLE: begin
                    // The store being enqueued this cycle also counts, so a
                    // lone store reaches the bridge one cycle after acceptance.
                    if (ld_accept) begin
                        rd_addr <= up_addr;
                        rd_size <= up_size;
                        state   <= RD_REQ;
                    end else if ((count != '0) || st_accept) begin
                        state <= WR_REQ;
                    end
                end
                WR_REQ: begin
                    if (dn_addr_ok) begin
                        state <= WR_WAIT;
                    end
                end
                WR_WAIT: begin
                    if (dn_data_ok) begin
                        state <= IDLE;
                    end
                end
                RD_REQ: begin
                    if (dn_addr_ok) begin
                        state <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (dn_data_ok) begin
                        rdata_q <= dn_rdata;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_write_buffer.sv
// tb_data_write_buffer
//   Directed bench for data_write_buffer. A transaction-level model (queue of
//   posted stores plus one outstanding bridge transaction) predicts the core
//   and bridge outputs every cycle; directed sequences add hand-computed
//   expectations. Honours WBUF_READ_BYPASS_EN the same way as the design.
module tb_data_write_buffer;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned AW    = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          up_req;
    logic          up_wr;
    logic [1:0]    up_size;
    logic [3:0]    up_wstrb;
    logic [AW-1:0] up_addr;
    logic [31:0]   up_wdata;
    logic          up_addr_ok;
    logic          up_data_ok;
    logic [31:0]   up_rdata;
    logic          dn_req;
    logic          dn_wr;
    logic [1:0]    dn_size;
    logic [3:0]    dn_wstrb;
    logic [AW-1:0] dn_addr;
    logic [31:0]   dn_wdata;
    logic          dn_addr_ok;
    logic          dn_data_ok;
    logic [31:0]   dn_rdata;

    data_write_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .up_req     (up_req),
        .up_wr      (up_wr),
        .up_size    (up_size),
        .up_wstrb   (up_wstrb),
        .up_addr    (up_addr),
        .up_wdata   (up_wdata),
        .up_addr_ok (up_addr_ok),
        .up_data_ok (up_data_ok),
        .up_rdata   (up_rdata),
        .dn_req     (dn_req),
        .dn_wr      (dn_wr),
        .dn_size    (dn_size),
        .dn_wstrb   (dn_wstrb),
        .dn_addr    (dn_addr),
        .dn_wdata   (dn_wdata),
        .dn_addr_ok (dn_addr_ok),
        .dn_data_ok (dn_data_ok),
        .dn_rdata   (dn_rdata)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Bridge responder: accepts immediately when enabled, completes
    // br_lat_cfg cycles after acceptance.
    logic        br_en;
    int unsigned br_lat_cfg;
    int unsigned br_cnt;
    logic [31:0] br_rdata;

    assign dn_addr_ok = dn_req & br_en;
    assign dn_data_ok = (br_cnt == 1);
    assign dn_rdata   = dn_data_ok ? br_rdata : '0;

    always @(posedge clk) begin
        if (reset)                   br_cnt <= 0;
        else if (dn_req && dn_addr_ok) br_cnt <= br_lat_cfg;
        else if (br_cnt != 0)        br_cnt <= br_cnt - 1;
    end

    // Bridge-side monitor: completed writes, drain order, first pop time.
    int unsigned   wr_done = 0;
    logic [AW-1:0] drain_log[$];
    bit            last_wr = 1'b0;
    bit            pop_arm = 1'b0;
    time           first_pop_t = 0;

    always @(negedge clk) begin
        if (!reset) begin
            if (dn_req && dn_addr_ok) begin
                last_wr = dn_wr;
                if (dn_wr) drain_log.push_back(dn_addr);
            end
            if (dn_data_ok && last_wr) begin
                wr_done++;
                if (pop_arm) begin
                    first_pop_t = $time;
                    pop_arm = 1'b0;
                end
            end
        end
    end

    // Transaction-level reference model.
    typedef struct packed {
        logic [AW-1:0] addr;
        logic [1:0]    size;
        logic [3:0]    wstrb;
        logic [31:0]   wdata;
    } ent_t;

    ent_t          mq[$];
    int            m_txn;      // 0 none, 1 write, 2 read
    bit            m_granted;
    bit            m_ack;
    logic [AW-1:0] m_raddr;
    logic [1:0]    m_rsize;
    logic [31:0]   m_rdata;

    function automatic bit load_clear(input logic [AW-1:0] a);
`ifdef WBUF_READ_BYPASS_EN
        foreach (mq[k]) if (mq[k].addr[AW-1:2] == a[AW-1:2]) return 1'b0;
        return 1'b1;
`else
        return mq.size() == 0;
`endif
    endfunction

    always @(negedge clk) begin : model
        bit          e_st, e_ld, e_dok, e_req, was_free;
        logic [31:0] e_rdata;
        ent_t        e;
        if (reset) begin
            mq.delete();
            m_txn     = 0;
            m_granted = 1'b0;
            m_ack     = 1'b0;
            m_rdata   = '0;
            m_raddr   = '0;
            m_rsize   = '0;
        end else begin
            e_st    = up_req && up_wr && (mq.size() < DEPTH) && (m_txn != 2);
            e_ld    = up_req && !up_wr && (m_txn == 0) && load_clear(up_addr) && !m_ack;
            e_dok   = m_ack || ((m_txn == 2) && m_granted && dn_data_ok);
            e_rdata = ((m_txn == 2) && m_granted) ? dn_rdata : m_rdata;
            e_req   = (m_txn != 0) && !m_granted;

            chk("m_up_addr_ok", up_addr_ok, e_st || e_ld);
            chk("m_up_data_ok", up_data_ok, e_dok);
            chk("m_up_rdata", up_rdata, e_rdata);
            chk("m_dn_req", dn_req, e_req);
            if (e_req && m_txn == 1) begin
                chk("m_wr_dn_wr", dn_wr, 1);
                chk("m_wr_dn_size", dn_size, mq[0].size);
                chk("m_wr_dn_wstrb", dn_wstrb, mq[0].wstrb);
                chk("m_wr_dn_addr", dn_addr, mq[0].addr);
                chk("m_wr_dn_wdata", dn_wdata, mq[0].wdata);
            end else if (e_req) begin
                chk("m_rd_dn_wr", dn_wr, 0);
                chk("m_rd_dn_size", dn_size, m_rsize);
                chk("m_rd_dn_wstrb", dn_wstrb, 0);
                chk("m_rd_dn_addr", dn_addr, m_raddr);
            end

            was_free = (m_txn == 0);
            if (m_txn != 0 && !m_granted) begin
                if (dn_addr_ok) m_granted = 1'b1;
            end else if (m_txn != 0 && dn_data_ok) begin
                if (m_txn == 1) mq.delete(0);
                else            m_rdata = dn_rdata;
                m_txn     = 0;
                m_granted = 1'b0;
            end
            if (e_st) begin
                e.addr  = up_addr;
                e.size  = up_size;
                e.wstrb = up_wstrb;
                e.wdata = up_wdata;
                mq.push_back(e);
            end
            if (was_free) begin
                if (e_ld) begin
                    m_txn   = 2;
                    m_raddr = up_addr;
                    m_rsize = up_size;
                end else if (mq.size() != 0) begin
                    m_txn = 1;
                end
            end
            m_ack = e_st;
        end
    end

    // Stimulus helpers
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        up_req   = 1'b0;
        up_wr    = 1'b0;
        up_size  = 2'd0;
        up_wstrb = 4'h0;
        up_addr  = '0;
        up_wdata = '0;
    endtask

    task automatic store(input logic [AW-1:0] a, input logic [31:0] d,
                         input logic [3:0] s, input logic [1:0] sz);
        up_req   = 1'b1;
        up_wr    = 1'b1;
        up_size  = sz;
        up_wstrb = s;
        up_addr  = a;
        up_wdata = d;
    endtask

    task automatic load(input logic [AW-1:0] a, input logic [1:0] sz);
        up_req   = 1'b1;
        up_wr    = 1'b0;
        up_size  = sz;
        up_wstrb = 4'h0;
        up_addr  = a;
        up_wdata = '0;
    endtask

    // Returns at the negedge of the cycle where the selected signal is high
    // (which: 0 = up_addr_ok, 1 = up_data_ok), or flags a timeout.
    task automatic wait_sig(input string name, input bit which, input int unsigned max,
                            output int unsigned n);
        bit hit;
        n   = 0;
        hit = 1'b0;
        while (!hit && n <= max) begin
            @(negedge clk);
            hit = which ? up_data_ok : up_addr_ok;
            if (!hit) begin
                n++;
                tick();
            end
        end
        if (!hit) chk({name, "_timeout"}, 0, 1);
    endtask

    task automatic wait_wr(input string name, input int unsigned target, input int unsigned max);
        int unsigned n;
        n = 0;
        while (wr_done < target && n < max) begin
            tick();
            n++;
        end
        if (wr_done < target) chk({name, "_drain_timeout"}, wr_done, target);
        tick();
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (got timeout, required completion)");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned n;
        int unsigned w0;
        time         t_acc;

        reset      = 1'b1;
        idle_in();
        br_en      = 1'b1;
        br_lat_cfg = 2;
        br_rdata   = '0;
        repeat (3) tick();
        reset = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_dn_req", dn_req, 0);
        chk("rst_up_data_ok", up_data_ok, 0);
        chk("rst_up_rdata", up_rdata, 0);
        tick();

        // Single store, 0-cycle addr_ok, 2-cycle data_ok
        w0 = wr_done;
        store(32'h1000, 32'hDEADBEEF, 4'hF, 2'd2);
        @(negedge clk);
        chk("st1_addr_ok", up_addr_ok, 1);
        chk("st1_no_ack_yet", up_data_ok, 0);
        chk("st1_no_dn_yet", dn_req, 0);
        tick();
        idle_in();
        @(negedge clk);
        chk("st1_ack", up_data_ok, 1);
        chk("st1_dn_req", dn_req, 1);
        chk("st1_dn_addr", dn_addr, 32'h1000);
        chk("st1_dn_wdata", dn_wdata, 32'hDEADBEEF);
        chk("st1_dn_wstrb", dn_wstrb, 4'hF);
        tick();
        @(negedge clk);
        chk("st1_ack_single", up_data_ok, 0);
        chk("st1_wait_no_req", dn_req, 0);
        wait_wr("st1", w0 + 1, 10);

        // Five stores against a stalled bridge
        br_en = 1'b0;
        drain_log.delete();
        w0 = wr_done;
        pop_arm = 1'b1;
        for (int i = 0; i < 5; i++) begin
            store(32'h100 + 4 * i, 32'hA0 + i, 4'hF, 2'd2);
            @(negedge clk);
            chk($sformatf("fill%0d_addr_ok", i), up_addr_ok, (i < 4) ? 1 : 0);
            if (i < 4) tick();
        end
        chk("stall_dn_req", dn_req, 1);
        chk("stall_head_addr", dn_addr, 32'h100);
        tick();
        br_en = 1'b1;
        wait_sig("fifth_accept", 1'b0, 20, n);
        t_acc = $time;
        chk("fifth_after_first_pop", t_acc - first_pop_t, 10);
        tick();
        idle_in();
        wait_wr("fill", w0 + 5, 60);
        chk("drain_count", drain_log.size(), 5);
        for (int i = 0; i < 5; i++) begin
            if (i < drain_log.size())
                chk($sformatf("drain_order%0d", i), drain_log[i], 32'h100 + 4 * i);
        end

        // Load behind a store to the same address
        w0 = wr_done;
        store(32'h2000, 32'h55, 4'h1, 2'd0);
        @(negedge clk);
        chk("st2000_addr_ok", up_addr_ok, 1);
        tick();
        load(32'h2000, 2'd0);
        br_rdata = 32'h55;
        @(negedge clk);
        chk("ld2000_held", up_addr_ok, 0);
        wait_sig("ld2000_accept", 1'b0, 20, n);
        chk("ld2000_after_drain", wr_done - w0, 1);
        tick();
        idle_in();
        wait_sig("ld2000_data", 1'b1, 20, n);
        chk("ld2000_rdata", up_rdata, 32'h55);
        tick();
        tick();
        @(negedge clk);
        chk("ld2000_rdata_held", up_rdata, 32'h55);
        tick();

`ifdef WBUF_READ_BYPASS_EN
        // Unrelated load overtakes a queued store
        w0 = wr_done;
        store(32'h3000, 32'h11, 4'hF, 2'd2);
        tick();
        store(32'h3004, 32'h22, 4'hF, 2'd2);
        tick();
        load(32'h4000, 2'd2);
        br_rdata = 32'h44;
        wait_sig("byp_ld_accept", 1'b0, 20, n);
        chk("byp_ld_before_drain", wr_done - w0, 1);
        tick();
        idle_in();
        @(negedge clk);
        chk("byp_rd_req", dn_req, 1);
        chk("byp_rd_wr", dn_wr, 0);
        chk("byp_rd_addr", dn_addr, 32'h4000);
        wait_sig("byp_ld_data", 1'b1, 20, n);
        chk("byp_ld_rdata", up_rdata, 32'h44);
        tick();
        wait_wr("byp", w0 + 2, 20);

        // Load to a queued word waits for that store
        w0 = wr_done;
        store(32'h3000, 32'h33, 4'hF, 2'd2);
        tick();
        store(32'h3004, 32'h66, 4'hF, 2'd2);
        tick();
        load(32'h3004, 2'd2);
        br_rdata = 32'h66;
        wait_sig("hit_ld_accept", 1'b0, 20, n);
        chk("hit_ld_after_both", wr_done - w0, 2);
        tick();
        idle_in();
        wait_sig("hit_ld_data", 1'b1, 20, n);
        chk("hit_ld_rdata", up_rdata, 32'h66);
        tick();
        tick();
`endif

        // Store presented while a load is outstanding
        br_lat_cfg = 4;
        br_rdata   = 32'h12345678;
        load(32'h5000, 2'd2);
        wait_sig("ld5000_accept", 1'b0, 5, n);
        tick();
        store(32'h6000, 32'h99, 4'hF, 2'd2);
        n = 0;
        begin
            bit done;
            done = 1'b0;
            while (!done && n < 20) begin
                @(negedge clk);
                chk("st_blocked_by_load", up_addr_ok, 0);
                if (up_data_ok) done = 1'b1;
                else begin
                    n++;
                    tick();
                end
            end
            if (!done) chk("ld5000_data_timeout", 0, 1);
        end
        chk("ld5000_rdata", up_rdata, 32'h12345678);
        tick();
        @(negedge clk);
        chk("st_after_load", up_addr_ok, 1);
        tick();
        idle_in();
        w0 = wr_done;
        wait_wr("st6000", w0 + 1, 20);

        // Reset with two entries queued and the FSM waiting on a write
        br_lat_cfg = 6;
        store(32'h7000, 32'hA, 4'hF, 2'd2);
        tick();
        store(32'h7004, 32'hB, 4'hF, 2'd2);
        @(negedge clk);
        chk("pre_rst_second_accept", up_addr_ok, 1);
        tick();
        idle_in();
        reset = 1'b1;
        @(negedge clk);
        chk("pre_rst_wr_wait", dn_req, 0);
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_dn_req", dn_req, 0);
        chk("post_rst_data_ok", up_data_ok, 0);
        chk("post_rst_rdata", up_rdata, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            @(negedge clk);
            chk($sformatf("post_rst_no_drain%0d", i), dn_req, 0);
        end
        br_lat_cfg = 2;
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_write_buffer.md
Name: data_write_buffer

Overview:
- Posted-write buffer between the core's data SRAM-like port and the SRAM-to-AXI bridge's data port.
- Stores are acknowledged to the core after one cycle and queued in a FIFO. The FIFO drains one transaction at a time to the bridge.
- Loads are forwarded to the bridge only when ordering against the queued stores is safe.
- The core sees in-order completion on both request types.

Parameters:
- DEPTH, 4, number of buffered stores; power of two, at least 2.
- AW, 32, address width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous reset, active-high
- up_req  in  1  core request valid
- up_wr  in  1  1 = store, 0 = load
- up_size  in  2  0 = byte, 1 = half, 2 = word
- up_wstrb  in  4  store byte enables
- up_addr  in  AW  request address
- up_wdata  in  32  store data
- up_addr_ok  out  1  request accepted this cycle
- up_data_ok  out  1  completion: load data valid, or store acknowledged
- up_rdata  out  32  load data
- dn_req  out  1  bridge request valid
- dn_wr  out  1  bridge request type
- dn_size  out  2  bridge access size
- dn_wstrb  out  4  bridge byte enables
- dn_addr  out  AW  bridge address
- dn_wdata  out  32  bridge store data
- dn_addr_ok  in  1  bridge accepted request
- dn_data_ok  in  1  bridge completion
- dn_rdata  in  32  bridge load data

Behaviour:
- Reset: all outputs 0; FIFO pointers and count 0; FSM to IDLE; ack flag 0. A reset during any state abandons in-flight work; the FIFO contents are discarded.
- FIFO entries hold {addr, size, wstrb, wdata}. count is $clog2(DEPTH)+1 bits wide. full = (count == DEPTH). Pointers wrap modulo DEPTH.
- rd_busy = FSM in RD_REQ or RD_WAIT.
- Store accept: up_addr_ok = up_req & up_wr & !full & !rd_busy, combinational. Acceptance enqueues the entry.
  - up_data_ok is pulsed exactly 1 cycle later, from a registered ack flag.
  - Enqueue is blocked when full, even if the head retires in the same cycle.
- Load accept: up_addr_ok = up_req & !up_wr & FSM == IDLE & rd_allowed & !ack_flag.
  - The load is latched into a read register and the FSM goes to RD_REQ.
- FSM states:
  - IDLE: if a load is acceptable, latch it and go to RD_REQ. Else, if count > 0, go to WR_REQ.
  - WR_REQ: dn_req=1, dn_wr=1, dn_* driven from the FIFO head. On dn_addr_ok go to WR_WAIT.
  - WR_WAIT: on dn_data_ok, pop the head (count-1) and go to IDLE.
  - RD_REQ: dn_req=1, dn_wr=0, dn_wstrb=0, dn_* driven from the read register. On dn_addr_ok go to RD_WAIT.
  - RD_WAIT: up_data_ok = dn_data_ok and up_rdata = dn_rdata, combinational. On dn_data_ok go to IDLE.
- dn_* fields are held stable while dn_req=1 and dn_addr_ok=0.
- Load priority over drain in IDLE applies only when rd_allowed.
- Simultaneous enqueue in any state and pop in WR_WAIT: count stays unchanged; both pointers advance.
- At most one bridge transaction is outstanding. dn_req is never asserted in WR_WAIT or RD_WAIT.
- up_data_ok never fires for a load and a store ack in the same cycle. Store accept is blocked while rd_busy, and load accept is blocked while ack_flag=1.
- Outside RD_WAIT, up_rdata holds its last value.

Optional Feature:
- Macro WBUF_READ_BYPASS_EN.
- Defined: rd_allowed = no valid FIFO entry (including an in-flight head) has addr[AW-1:2] equal to up_addr[AW-1:2]. Loads to unrelated words overtake queued stores.
- Undefined: rd_allowed = (count == 0). Loads wait until the FIFO is fully drained.

Test Plan:
- Store to 0x1000 (wdata 0xDEADBEEF, wstrb 0xF), bridge with 0-cycle addr_ok and 2-cycle data_ok:
  - up_addr_ok same cycle; up_data_ok next cycle.
  - dn_req with addr 0x1000 and wdata 0xDEADBEEF appears 1 cycle after accept.
- Five back-to-back stores with the bridge stalled (dn_addr_ok=0), DEPTH=4:
  - First four accepted; fifth sees up_addr_ok=0.
  - Releasing the bridge drains entries in order 0,1,2,3. The fifth is accepted after the first pop.
- Store 0x55 to 0x2000, then load from 0x2000 while the store is queued:
  - Load is held until count==0.
  - dn_rdata 0x55 is returned on up_data_ok.
- With WBUF_READ_BYPASS_EN: queue stores to 0x3000 and 0x3004, then issue a load to 0x4000:
  - Load issues on dn_* before the stores drain.
  - A load to 0x3004 instead waits for its matching store to retire.
- Load outstanding in RD_WAIT while the core presents a store: up_addr_ok=0 until after the load's up_data_ok.
- Assert reset with 2 entries queued and the FSM in WR_WAIT: next cycle dn_req=0, count=0, state IDLE, up_data_ok=0.
